// File: rtl/cdc_ctrl_pkg.sv
// Shared types and constants for the gray-counter CDC snapshot sequencer.
// Holds the FSM state enum, default phase lengths and the phase-timer width helper.
package cdc_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    FREEZE,
    LOAD,
    SETTLE
  } state_t;

  localparam int DEF_HOLD_CYC   = 1;
  localparam int DEF_LOAD_CYC   = 3;
  localparam int DEF_SETTLE_CYC = 3;

  // Wide enough to hold the longest phase length or the auto period.
  function automatic int phase_w(input int hold, input int load, input int settle,
                                 input int period);
    int m;
    m = hold;
    if (load > m)   m = load;
    if (settle > m) m = settle;
    if (period > m) m = period;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cdc_snap_ctrl_phase_timer.sv
// Loadable down-counter with terminal-count flag; used for phase lengths and the auto period.
// The count saturates at zero so tc stays asserted until the next load.
module phase_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         tc
);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (en && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign tc = (count_reg == '0);

endmodule

// File: rtl/cdc_snap_ctrl.sv
// Source-domain sequencer for the gray-counter CDC path: freezes the counter, raises load
// long enough to cross the synchronizer, then lets counting resume.
module cdc_snap_ctrl
  import cdc_ctrl_pkg::*;
#(
  parameter int HOLD_CYC   = DEF_HOLD_CYC,
  parameter int LOAD_CYC   = DEF_LOAD_CYC,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int PERIOD     = 0,
  parameter int SNAP_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              snap_req,
  output logic              cnt_en,
  output logic              load,
  output logic              busy,
  output logic              snap_done,
  output logic [SNAP_W-1:0] snap_cnt
);

  localparam int PW = phase_w(HOLD_CYC, LOAD_CYC, SETTLE_CYC, PERIOD);
  localparam logic [PW-1:0] HOLD_LD   = PW'(HOLD_CYC - 1);
  localparam logic [PW-1:0] LOAD_LD   = PW'(LOAD_CYC - 1);
  localparam logic [PW-1:0] SETTLE_LD = PW'(SETTLE_CYC - 1);
  localparam logic [PW-1:0] AUTO_LD   = (PERIOD > 0) ? PW'(PERIOD - 1) : '0;
  localparam bit            AUTO_ON   = (PERIOD > 0);

  state_t            state_reg, state_next;
  logic              run_reg, run_next;
  logic              pend_reg, pend_next;
  logic              phase_load;
  logic [PW-1:0]     phase_val;
  logic              phase_tc;
  logic              auto_tc;
  logic              auto_tick;
  logic              done_next;
  logic              cnt_en_reg, load_reg, busy_reg, snap_done_reg;
  logic [SNAP_W-1:0] snap_cnt_reg;

  phase_timer #(.W(PW)) u_phase (
    .clk      (clk),
    .rst      (rst),
    .load     (phase_load),
    .load_val (phase_val),
    .en       (1'b1),
    .tc       (phase_tc)
  );

  // The auto timer is held at its reload value whenever the block is not running.
  phase_timer #(.W(PW)) u_auto (
    .clk      (clk),
    .rst      (rst),
    .load     (state_reg != RUN),
    .load_val (AUTO_LD),
    .en       (state_reg == RUN),
    .tc       (auto_tc)
  );

  assign auto_tick = AUTO_ON && (state_reg == RUN) && auto_tc;

  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    pend_next  = pend_reg;
    phase_load = 1'b0;
    phase_val  = HOLD_LD;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (snap_req) begin
          state_next = FREEZE;
          run_next   = 1'b0;
          phase_load = 1'b1;
        end else if (start && !stop) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (snap_req || auto_tick) begin
          state_next = FREEZE;
          run_next   = !stop;
          phase_load = 1'b1;
        end else if (stop) begin
          state_next = IDLE;
        end
      end
      FREEZE, LOAD, SETTLE: begin
        if (stop) begin
          run_next = 1'b0;
        end else if (start) begin
          run_next = 1'b1;
        end
        if (snap_req) pend_next = 1'b1;
        if (phase_tc) begin
          phase_load = 1'b1;
          if (state_reg == FREEZE) begin
            state_next = LOAD;
            phase_val  = LOAD_LD;
          end else if (state_reg == LOAD) begin
            state_next = SETTLE;
            phase_val  = SETTLE_LD;
          end else begin
            // A merged pending request relaunches straight away, keeping the counter frozen.
            done_next = 1'b1;
            if (pend_next) begin
              state_next = FREEZE;
              pend_next  = 1'b0;
            end else begin
              state_next = run_next ? RUN : IDLE;
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      run_reg       <= 1'b0;
      pend_reg      <= 1'b0;
      cnt_en_reg    <= 1'b0;
      load_reg      <= 1'b0;
      busy_reg      <= 1'b0;
      snap_done_reg <= 1'b0;
      snap_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      run_reg       <= run_next;
      pend_reg      <= pend_next;
      cnt_en_reg    <= (state_next == RUN);
      load_reg      <= (state_next == LOAD);
      busy_reg      <= (state_next == FREEZE) || (state_next == LOAD) || (state_next == SETTLE);
      snap_done_reg <= done_next;
      if (done_next) snap_cnt_reg <= snap_cnt_reg + 1'b1;
    end
  end

  assign cnt_en    = cnt_en_reg;
  assign load      = load_reg;
  assign busy      = busy_reg;
  assign snap_done = snap_done_reg;
  assign snap_cnt  = snap_cnt_reg;

endmodule

// File: tb/tb_cdc_snap_ctrl.sv
// Bench for cdc_snap_ctrl: directed vector table, multi-cycle corner sequences,
// randomized run against a schedule-based model, and an auto-period instance.
module tb_cdc_snap_ctrl;

  localparam int H = 1;
  localparam int L = 3;
  localparam int S = 3;
  localparam int B = H + L + S;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, stop, snap_req;
  logic        cnt_en, load, busy, snap_done;
  logic [15:0] snap_cnt;

  logic        a_rst, a_start, a_stop, a_req;
  logic        a_cnt_en, a_load, a_busy, a_done;
  logic [15:0] a_cnt;

  cdc_snap_ctrl #(.HOLD_CYC(H), .LOAD_CYC(L), .SETTLE_CYC(S), .PERIOD(0), .SNAP_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .snap_req(snap_req),
    .cnt_en(cnt_en), .load(load), .busy(busy), .snap_done(snap_done), .snap_cnt(snap_cnt)
  );

  cdc_snap_ctrl #(.HOLD_CYC(H), .LOAD_CYC(L), .SETTLE_CYC(S), .PERIOD(20), .SNAP_W(16)) dut_auto (
    .clk(clk), .rst(a_rst), .start(a_start), .stop(a_stop), .snap_req(a_req),
    .cnt_en(a_cnt_en), .load(a_load), .busy(a_busy), .snap_done(a_done), .snap_cnt(a_cnt)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit r, s, p, q;
    bit ce, ld, bz, dn;
    int cnt;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, s, p, q, ce, ld, bz, dn, input int cnt);
    vec_t v;
    v.r = r; v.s = s; v.p = p; v.q = q;
    v.ce = ce; v.ld = ld; v.bz = bz; v.dn = dn; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  // Model: a sequence is a fixed B-cycle schedule indexed by m_t.
  bit        m_run, m_busy, m_flag, m_pend, m_done;
  int        m_t;
  bit [15:0] m_cnt;

  task automatic model_step(input bit r, input bit s, input bit p, input bit q);
    if (r) begin
      m_run = 0; m_busy = 0; m_flag = 0; m_pend = 0; m_done = 0; m_t = 0; m_cnt = 0;
      return;
    end
    m_done = 0;
    if (m_busy) begin
      if (p) m_flag = 0;
      else if (s) m_flag = 1;
      if (q) m_pend = 1;
      if (m_t == B - 1) begin
        m_done = 1;
        m_cnt  = m_cnt + 16'd1;
        if (m_pend) begin
          m_pend = 0;
          m_t    = 0;
        end else begin
          m_busy = 0;
          m_run  = m_flag;
        end
      end else begin
        m_t++;
      end
    end else if (q) begin
      m_busy = 1;
      m_t    = 0;
      m_flag = m_run && !p;
    end else if (m_run && p) begin
      m_run = 0;
    end else if (!m_run && s && !p) begin
      m_run = 1;
    end
  endtask

  initial begin
    int first_done, second_done, ndone, ce_early, ce_at_second, viol;
    int rises[$];
    bit prev_load;
    bit r, s, p, q;
    bit e_ce, e_ld;

    rst = 1; start = 0; stop = 0; snap_req = 0;
    a_rst = 1; a_start = 0; a_stop = 0; a_req = 0;

    // rst start stop req | cnt_en load busy done snap_cnt
    add(1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 1, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 1, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 1, 0, 0, 1, 0, 0, 0, 2);
    add(0, 0, 1, 0, 0, 0, 0, 0, 2);
    add(0, 1, 1, 0, 0, 0, 0, 0, 2);

    tick();
    foreach (vecs[i]) begin
      rst = vecs[i].r; start = vecs[i].s; stop = vecs[i].p; snap_req = vecs[i].q;
      tick();
      $display("vec %0d: in r%0d s%0d p%0d q%0d -> cnt_en=%0d load=%0d busy=%0d done=%0d cnt=%0d",
               i, rst, start, stop, snap_req, cnt_en, load, busy, snap_done, snap_cnt);
      chk($sformatf("vec%0d", i), {cnt_en, load, busy, snap_done, snap_cnt},
          {vecs[i].ce, vecs[i].ld, vecs[i].bz, vecs[i].dn, 16'(vecs[i].cnt)});
    end
    start = 0; stop = 0; snap_req = 0;

    // Two requests while busy merge into one back-to-back sequence.
    rst = 1; tick(); rst = 0;
    start = 1; tick(); start = 0; tick();
    snap_req = 1; tick(); snap_req = 0;
    first_done = -1; second_done = -1; ndone = 0; ce_early = 0; ce_at_second = 0;
    for (int k = 0; k < 20; k++) begin
      snap_req = (k == 1) || (k == 3);
      tick();
      if (snap_done) begin
        if (ndone == 0) first_done = k;
        else if (ndone == 1) begin
          second_done = k;
          ce_at_second = cnt_en;
        end
        ndone++;
      end
      if (ndone < 2 && cnt_en) ce_early++;
    end
    snap_req = 0;
    $display("merge: done at %0d and %0d, snap_cnt=%0d", first_done, second_done, snap_cnt);
    chk("merge_ndone", ndone, 2);
    chk("merge_first", first_done, B - 1);
    chk("merge_gap", second_done - first_done, B);
    chk("merge_cnt_en_held", ce_early, 0);
    chk("merge_resume", ce_at_second, 1);
    chk("merge_snap_cnt", snap_cnt, 2);

    // Reset during LOAD with a pending request outstanding.
    rst = 1; tick(); rst = 0;
    start = 1; tick(); start = 0;
    snap_req = 1; tick(); snap_req = 0; tick();
    snap_req = 1; tick(); snap_req = 0;
    chk("rstload_in_load", load, 1);
    rst = 1; tick(); rst = 0;
    $display("rst in LOAD: cnt_en=%0d load=%0d busy=%0d cnt=%0d", cnt_en, load, busy, snap_cnt);
    chk("rstload_outputs", {cnt_en, load, busy, snap_done, snap_cnt}, 0);
    viol = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (busy || cnt_en || load) viol++;
    end
    chk("rstload_no_pending", viol, 0);

    // Randomized run against the schedule model.
    rst = 1; model_step(1, 0, 0, 0); tick(); rst = 0;
    viol = 0;
    for (int c = 0; c < 2000; c++) begin
      r = ($urandom_range(99) == 0);
      s = ($urandom_range(9) == 0);
      p = ($urandom_range(19) == 0);
      q = ($urandom_range(11) == 0);
      rst = r; start = s; stop = p; snap_req = q;
      model_step(r, s, p, q);
      tick();
      e_ce = !m_busy && m_run;
      e_ld = m_busy && (m_t >= H) && (m_t < H + L);
      chk($sformatf("rand%0d", c), {cnt_en, load, busy, snap_done, snap_cnt},
          {e_ce, e_ld, m_busy, m_done, m_cnt});
      if (load && cnt_en) viol++;
    end
    rst = 0; start = 0; stop = 0; snap_req = 0;
    chk("rand_load_vs_cnt_en", viol, 0);
    $display("random: %0d cycles, model snap_cnt=%0d dut snap_cnt=%0d", 2000, m_cnt, snap_cnt);

    // Auto mode, PERIOD=20: 20 RUN cycles then a 7-cycle sequence, repeated.
    a_rst = 1; tick(); a_rst = 0;
    a_start = 1; tick(); a_start = 0;
    prev_load = a_load; ndone = 0; viol = 0;
    first_done = 0;
    for (int k = 0; k < 400 && ndone < 5; k++) begin
      tick();
      if (a_load && !prev_load) rises.push_back(k);
      prev_load = a_load;
      if (a_done) ndone++;
      if (a_busy) first_done++;
      if (a_load && a_cnt_en) viol++;
    end
    $display("auto: %0d load rises, %0d done pulses, snap_cnt=%0d", rises.size(), ndone, a_cnt);
    chk("auto_rises", rises.size(), 5);
    if (rises.size() == 5) begin
      chk("auto_first_rise", rises[0], 20);
      for (int i = 1; i < 5; i++) chk($sformatf("auto_interval%0d", i), rises[i] - rises[i-1], 27);
    end
    chk("auto_snap_cnt", a_cnt, 5);
    chk("auto_busy_cycles", first_done, 5 * B);
    chk("auto_load_vs_cnt_en", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/cdc_snap_ctrl.md
Name: cdc_snap_ctrl

Overview:
Source-domain sequencer for the gray-counter CDC path. Drives the counter's count-enable and load strobe so the gray value stays frozen while the load strobe crosses the synchronizer with it. Snapshots come from an external request or a periodic auto-timer. Sits beside the gray counter on the source clock; its load output feeds the counter's load input and the synchronizer's load bit.

Parameters:
HOLD_CYC, 1, cycles the counter is frozen before load asserts (min 1)
LOAD_CYC, 3, cycles load stays high; at least synchronizer depth + 1 (min 1)
SETTLE_CYC, 3, cycles after load drops before counting resumes (min 1)
PERIOD, 0, auto-snapshot interval in RUN cycles; 0 disables auto mode
SNAP_W, 16, width of the completed-snapshot counter

Ports:
clk  in  1  source-domain clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; begin counting
stop  in  1  pulse; stop counting
snap_req  in  1  pulse; request a snapshot transfer
cnt_en  out  1  to counter enable; registered
load  out  1  to counter load and synchronizer load bit; registered
busy  out  1  high in FREEZE, LOAD and SETTLE
snap_done  out  1  one-cycle pulse when a snapshot sequence completes
snap_cnt  out  SNAP_W  number of completed snapshots; wraps modulo 2^SNAP_W

Behaviour:
- Reset (rst sampled high at a clk edge): state IDLE; cnt_en=0, load=0, busy=0, snap_done=0, snap_cnt=0; pending flag, run flag and timers cleared. Reset mid-sequence aborts at once and load drops on the next edge.
- States:
  - IDLE: cnt_en=0.
  - RUN: cnt_en=1.
  - FREEZE: cnt_en=0, load=0, lasts HOLD_CYC cycles.
  - LOAD: cnt_en=0, load=1, lasts LOAD_CYC cycles.
  - SETTLE: cnt_en=0, load=0, lasts SETTLE_CYC cycles.
- Transitions:
  - IDLE→RUN on start. start and stop together in IDLE → stay IDLE.
  - RUN→IDLE on stop.
  - IDLE or RUN→FREEZE on a snapshot request (snap_req, pending flag, or auto tick). The run flag records the origin: 1 if from RUN.
  - FREEZE→LOAD→SETTLE after the respective counts.
  - SETTLE exits to RUN if the run flag is 1, otherwise to IDLE.
- Latency: snap_req sampled at edge N in RUN:
  - cnt_en=0 from cycle N+1.
  - load=1 for cycles N+1+HOLD_CYC … N+HOLD_CYC+LOAD_CYC.
  - snap_done=1 and snap_cnt incremented in the first cycle after SETTLE; cnt_en=1 again in that same cycle if returning to RUN.
  - Total busy time is HOLD_CYC+LOAD_CYC+SETTLE_CYC cycles.
- During a sequence (busy=1):
  - stop clears the run flag; the sequence completes, then the block goes IDLE.
  - start sets the run flag.
  - snap_req sets a single pending flag; further requests merge into it. The pending flag launches a new FREEZE directly from SETTLE exit; snap_done still pulses, and cnt_en stays 0.
- stop and snap_req together in RUN: the snapshot is taken, the run flag is cleared, and the block ends in IDLE.
- Auto timer:
  - Counts only in RUN; requests a snapshot when it reaches PERIOD-1.
  - Clears on entering FREEZE or IDLE.
  - An auto tick while busy is impossible by construction.
- load is never high while cnt_en is high, and never high in two consecutive sequences without at least SETTLE_CYC low cycles between them.

Decomposition:
- Package cdc_ctrl_pkg holds:
  - the state enum (IDLE, RUN, FREEZE, LOAD, SETTLE);
  - default constants for HOLD_CYC, LOAD_CYC and SETTLE_CYC;
  - a function returning the phase-counter width, clog2 of max(HOLD_CYC, LOAD_CYC, SETTLE_CYC, PERIOD) + 1.
- One sub-module, phase_timer: loadable down-counter with a terminal-count flag, reused for the phase length and the auto period.

Test Plan:
- Reset then start: cnt_en=1 on the next cycle; load=0, busy=0, snap_cnt=0.
- RUN, snap_req at cycle 10 with defaults: cnt_en=0 for cycles 11–17; load=1 for cycles 12–14; snap_done=1 and cnt_en=1 at cycle 18; snap_cnt=1.
- snap_req twice during busy: exactly one extra sequence follows back-to-back with cnt_en held 0 between them; snap_cnt=2; two snap_done pulses 7 cycles apart.
- stop during LOAD: load still lasts 3 cycles; after SETTLE the block is IDLE with cnt_en=0; snap_done still pulses.
- PERIOD=20, start, no snap_req: load rises every 27 cycles (20 RUN + 7 busy); after 5 sequences snap_cnt=5.
- rst asserted during LOAD: the next cycle shows load=0, cnt_en=0, busy=0, snap_cnt=0, and the pending flag is cleared (no further sequence).
